// File: rtl/aib_avmm_cfg_pkg.sv
// Shared types and address-map constants for the per-channel AIB Avalon-MM config responder.
package aib_avmm_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StResp
  } cfg_state_e;

  localparam int unsigned CH_MSB  = 16;
  localparam int unsigned CH_LSB  = 11;
  localparam int unsigned IDX_MSB = 10;
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;

  localparam int unsigned ERR_COLL_BIT = 0;
  localparam int unsigned ERR_OOR_BIT  = 1;

endpackage

// File: rtl/aib_avmm_cfg_regfile.sv
// Byte-writable NUM_REGS x 32 config register array with a zero-default read mux and a flat image.
module aib_avmm_cfg_regfile
  import aib_avmm_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [3:0]               i_byte_en,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic [NUM_REGS*32-1:0]   o_cfg_regs
);

  logic [31:0] regs_q [NUM_REGS];

  // Index compares against every slot so out-of-range indices simply match nothing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (i_we) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_idx == IDX_W'(k) && i_byte_en[b]) begin
            regs_q[k][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_rdata = regs_q[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_cfg_regs[32*g +: 32] = regs_q[g];
  end

endmodule

// File: rtl/aib_avmm_cfg_responder.sv
// Per-channel Avalon-MM config responder: IDLE/ACK/RESP handshake in front of the register file.
// Optional sticky error status register at index NUM_REGS when AIB_AVMM_CFG_ERR_EN is defined.
module aib_avmm_cfg_responder
  import aib_avmm_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                   i_cfg_avmm_clk,
  input  logic                   i_cfg_avmm_rst_n,
  input  logic [5:0]             i_channel_id,
  input  logic [16:0]            i_cfg_avmm_addr,
  input  logic                   i_cfg_avmm_read,
  input  logic                   i_cfg_avmm_write,
  input  logic [3:0]             i_cfg_avmm_byte_en,
  input  logic [31:0]            i_cfg_avmm_wdata,
  output logic                   o_cfg_avmm_waitreq,
  output logic                   o_cfg_avmm_rdatavld,
  output logic [31:0]            o_cfg_avmm_rdata,
  output logic [NUM_REGS*32-1:0] o_cfg_regs
);

  cfg_state_e       state_q, state_d;
  logic             hit;
  logic             accept;
  logic             wr_q, rd_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rf_rdata;
  logic [31:0]      rd_word;
  logic             rf_we;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^i_cfg_avmm_addr[1:0];

  assign hit    = (i_cfg_avmm_read | i_cfg_avmm_write) &&
                  (i_cfg_avmm_addr[CH_MSB:CH_LSB] == i_channel_id);
  assign accept = (state_q == StIdle) && hit;

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    o_cfg_avmm_waitreq  = 1'b1;
    o_cfg_avmm_rdatavld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) state_d = StAck;
      end
      StAck: begin
        o_cfg_avmm_waitreq = 1'b0;
        state_d            = rd_q ? StResp : StIdle;
      end
      StResp: begin
        o_cfg_avmm_rdatavld = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The request is frozen at acceptance; a master dropping it during ACK cannot abort it.
  // A simultaneous read+write is executed as a write only.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= i_cfg_avmm_write;
      rd_q    <= i_cfg_avmm_read & ~i_cfg_avmm_write;
      idx_q   <= i_cfg_avmm_addr[IDX_MSB:IDX_LSB];
      be_q    <= i_cfg_avmm_byte_en;
      wdata_q <= i_cfg_avmm_wdata;
    end
  end

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      rdata_q <= '0;
    end else if ((state_q == StAck) && rd_q) begin
      rdata_q <= rd_word;
    end
  end

  assign rf_we            = (state_q == StAck) && wr_q;
  assign o_cfg_avmm_rdata = (state_q == StResp) ? rdata_q : '0;

  aib_avmm_cfg_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk      (i_cfg_avmm_clk),
    .i_rst_n    (i_cfg_avmm_rst_n),
    .i_we       (rf_we),
    .i_idx      (idx_q),
    .i_byte_en  (be_q),
    .i_wdata    (wdata_q),
    .o_rdata    (rf_rdata),
    .o_cfg_regs (o_cfg_regs)
  );

`ifdef AIB_AVMM_CFG_ERR_EN
  logic       coll_q;
  logic [1:0] err_q;
  logic [1:0] err_set, err_clr;
  logic       is_status;

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      coll_q <= 1'b0;
    end else if (accept) begin
      coll_q <= i_cfg_avmm_read & i_cfg_avmm_write;
    end
  end

  assign is_status = (32'(idx_q) == NUM_REGS);

  always_comb begin
    err_set               = '0;
    err_set[ERR_COLL_BIT] = coll_q;
    err_set[ERR_OOR_BIT]  = (32'(idx_q) > NUM_REGS);
    err_clr               = (wr_q && is_status && be_q[0]) ? wdata_q[1:0] : 2'b00;
  end

  // Set is OR-ed after the clear so a same-cycle event survives a W1C.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      err_q <= '0;
    end else if (state_q == StAck) begin
      err_q <= (err_q & ~err_clr) | err_set;
    end
  end

  assign rd_word = is_status ? {30'b0, err_q} : rf_rdata;
`else
  assign rd_word = rf_rdata;
`endif

endmodule

// File: doc/aib_avmm_cfg_responder.md
# aib_avmm_cfg_responder

Per-channel Avalon-MM configuration responder that terminates the channel's `i_cfg_avmm_*` access bus. It completes every access with a defined waitrequest/readdatavalid handshake and holds a byte-writable 32-bit register file. The register file drives the adapter's static configuration bus. One instance sits in each AIB channel, between the configuration initiator and the adapter configuration inputs.

## Interface
- `NUM_REGS`, 16: number of 32-bit config registers; legal range 1..512.
- `i_cfg_avmm_clk` in 1: the block's only clock.
- `i_cfg_avmm_rst_n` in 1: asynchronous, active-low reset.
- `i_channel_id` in 6: this channel's ID; quasi-static.
- `i_cfg_avmm_addr` in 17: byte address.
  - [16:11] channel select.
  - [10:2] word index.
  - [1:0] ignored.
- `i_cfg_avmm_read` in 1: read request; held until the cycle in which waitreq is low.
- `i_cfg_avmm_write` in 1: write request; held until the cycle in which waitreq is low.
- `i_cfg_avmm_byte_en` in 4: byte lane enables for writes.
- `i_cfg_avmm_wdata` in 32: write data.
- `o_cfg_avmm_waitreq` out 1: stall; low for exactly one cycle to accept a request.
- `o_cfg_avmm_rdatavld` out 1: one-cycle read-data-valid pulse.
- `o_cfg_avmm_rdata` out 32: read data; valid only while rdatavld is high, 0 otherwise.
- `o_cfg_regs` out NUM_REGS*32: flat register image; register k occupies [32k+31:32k].

## Operation
- State machine states: IDLE, ACK, RESP.
- IDLE:
  - waitreq=1.
  - A request is sampled when read|write is high and addr[16:11]==i_channel_id.
  - On a hit, go to ACK.
  - A mismatched channel produces no state change and no response; another channel owns that access.
- ACK (1 cycle):
  - waitreq=0.
  - A write commits at the clock edge that ends ACK, for byte lanes with byte_en=1 and index<NUM_REGS. Then go to IDLE.
  - A read captures the selected word, or 0 if index>=NUM_REGS. Then go to RESP.
- RESP (1 cycle):
  - rdatavld=1 with the captured data. Then go to IDLE.
  - waitreq stays 1, so a new request cannot be accepted before IDLE.
- read and write both high on a hit: the access is executed as a write and the read is dropped (no rdatavld).
- Writes with byte_en=0: accepted and completed with no register change.
- Out-of-range index:
  - Writes are dropped.
  - Reads return 32'h0000_0000.
- Registers reset to 0. `o_cfg_regs` is driven directly from the register flops (no added latency).
- A request deasserted while the FSM is in ACK (protocol violation): the access still completes as sampled at IDLE; request signals are re-sampled only in IDLE.

## Timing
- Reset values:
  - waitreq=1.
  - rdatavld=0.
  - rdata=0.
  - `o_cfg_regs`=0.
  - state=IDLE.
- Write: request visible at edge N, waitreq low in cycle N+1, register updated at edge N+2 (visible on `o_cfg_regs` in cycle N+2).
- Read: waitreq low in cycle N+1, rdatavld/rdata in cycle N+2.
- Back-to-back accesses:
  - Writes: one every 2 cycles.
  - Reads: one every 3 cycles.
- Reset asserted mid-access:
  - All outputs go immediately to their reset values.
  - An in-flight write is lost and no rdatavld is produced.
  - After deassertion the FSM starts in IDLE.

## Configuration
- `AIB_AVMM_CFG_ERR_EN` defined: adds a status register at word index NUM_REGS.
  - bit0 sticky: rd&wr collision.
  - bit1 sticky: out-of-range access. Index NUM_REGS itself is not out-of-range; index >NUM_REGS is.
  - Bits 31:2 read 0.
  - Clear by writing 1 to a bit with byte_en[0]=1 (write-1-to-clear).
  - If a clear and a new error event hit the same bit in the same cycle, the set wins.
  - The status register does not appear on `o_cfg_regs`.
- `AIB_AVMM_CFG_ERR_EN` undefined:
  - No status logic.
  - Index NUM_REGS behaves as out-of-range.

## Structure
- Package `aib_avmm_cfg_pkg` contains:
  - The state enum (IDLE/ACK/RESP).
  - Address slice constants CH_MSB=16, CH_LSB=11, IDX_MSB=10, IDX_LSB=2.
  - Error bit positions.
- Sub-module `aib_avmm_cfg_regfile` contains:
  - The NUM_REGS×32 array with byte-enable write port.
  - A combinational read mux returning 0 out of range.
  - The flat `o_cfg_regs` output.
- The FSM, handshake and error logic live in the top.

## Test plan
- Write 32'hA5A5_1234, be=4'hF, index 3, channel match.
  - waitreq low 1 cycle after the request.
  - `o_cfg_regs`[127:96]=32'hA5A5_1234 one cycle later.
  - Readback gives rdatavld with rdata=32'hA5A5_1234, 2 cycles after the read request.
- Write 32'hFFFF_FFFF with be=4'b0101 onto 0 in index 0.
  - Register reads 32'h00FF_00FF.
- Access with addr[16:11]≠i_channel_id (e.g. ID 5, addr channel 6).
  - waitreq stays 1 for 10 cycles.
  - No rdatavld.
  - No register change.
- Read at index NUM_REGS+1 (and NUM_REGS with the macro undefined).
  - rdata=0 with rdatavld.
  - With the macro defined, status bit1=1; writing 32'h2 clears it.
- read=write=1, wdata=32'h0000_00C3, index 2.
  - Register 2=32'hC3.
  - No rdatavld.
  - With the macro defined, status bit0=1.
- Assert reset during the ACK cycle of a write to index 1.
  - Register 1 stays 0.
  - waitreq=1 and rdatavld=0 immediately.
  - A subsequent write completes normally.
